// File: rtl/shift_serializer_pkg.sv
// Shared types for the shift serializer: manual operation codes, FSM states,
// and the width helper used to size the burst bit counter.
package shift_pkg;

  typedef enum logic [2:0] {
    HOLD = 3'd0,
    LOAD = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    ROL  = 3'd4,
    ROR  = 3'd5
  } mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter width able to hold the value WIDTH itself (count after a full burst).
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_serializer_if.sv
// Bus bundle between a datapath/link controller (master) and the shift serializer (slave).
interface shift_serializer_if
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
);

  localparam int CW = count_width(WIDTH);

  logic [2:0]       mode;
  logic             start;
  logic             serial_in;
  logic [WIDTH-1:0] parallel_in;
  logic             serial_out;
  logic [WIDTH-1:0] reg_content;
  logic             busy;
  logic             done;
  logic [CW-1:0]    bit_count;

  modport master (
    output mode, start, serial_in, parallel_in,
    input  serial_out, reg_content, busy, done, bit_count
  );

  modport slave (
    input  mode, start, serial_in, parallel_in,
    output serial_out, reg_content, busy, done, bit_count
  );

endinterface

// File: rtl/shift_serializer_bit_counter.sv
// Generic serial bit counter: clear, increment, and a terminal flag raised when
// the count sits at WIDTH-1, so the owner knows the current shift is the last one.
module bit_counter
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = count_width(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          incr,
  output logic [CW-1:0] count,
  output logic          terminal
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Count register: clear wins over increment so a new burst always starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr) begin
      count <= count + CW'(1);
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/shift_serializer.sv
// Universal shift register with a self-timed full-duplex burst: manual
// hold/load/shift/rotate in IDLE, or a WIDTH-bit serial exchange in SHIFT.
module shift_serializer
  import shift_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               reset,
  shift_serializer_if.slave bus
);

  localparam int CW = count_width(WIDTH);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_next;
  logic [WIDTH-1:0] burst_shift;
  logic             cnt_clear;
  logic             cnt_incr;
  logic             cnt_terminal;
  logic [CW-1:0]    cnt;
  logic             done_next;
  logic             done_q;

  bit_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .incr    (cnt_incr),
    .count   (cnt),
    .terminal(cnt_terminal)
  );

  // The burst always moves bits toward serial_out and fills from serial_in at the far end.
  assign burst_shift = MSB_FIRST ? {data[WIDTH-2:0], bus.serial_in}
                                 : {bus.serial_in, data[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: a burst starts on start and ends on the shift where the counter is terminal.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = SHIFT;
      SHIFT:   if (cnt_terminal) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath and counter control: burst shifting beats start, start beats the manual mode.
  always_comb begin
    data_next = data;
    cnt_clear = 1'b0;
    cnt_incr  = 1'b0;
    done_next = 1'b0;
    if (state == SHIFT) begin
      data_next = burst_shift;
      cnt_incr  = 1'b1;
      done_next = cnt_terminal;
    end else if (bus.start) begin
      data_next = bus.parallel_in;
      cnt_clear = 1'b1;
    end else begin
      case (mode_t'(bus.mode))
        LOAD:    data_next = bus.parallel_in;
        SHL:     data_next = {data[WIDTH-2:0], bus.serial_in};
        SHR:     data_next = {bus.serial_in, data[WIDTH-1:1]};
        ROL:     data_next = {data[WIDTH-2:0], data[WIDTH-1]};
        ROR:     data_next = {data[0], data[WIDTH-1:1]};
        default: data_next = data;
      endcase
    end
  end

  // Shift register storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
    end else begin
      data <= data_next;
    end
  end

  // Registered one-cycle done pulse following the final burst shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_next;
    end
  end

  assign bus.serial_out  = MSB_FIRST ? data[WIDTH-1] : data[0];
  assign bus.reg_content = data;
  assign bus.busy        = (state == SHIFT);
  assign bus.done        = done_q;
  assign bus.bit_count   = cnt;

endmodule

// File: tb/tb_shift_serializer.sv
// Self-checking bench for shift_serializer: table-driven manual ops plus
// hand-written burst sequences, expectations flowing through a scoreboard queue.
module tb_shift_serializer;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic reset_m;
  logic reset_l;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  shift_serializer_if #(.WIDTH(8)) bus_m ();
  shift_serializer_if #(.WIDTH(8)) bus_l ();

  shift_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk  (clk),
    .reset(reset_m),
    .bus  (bus_m)
  );

  shift_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk  (clk),
    .reset(reset_l),
    .bus  (bus_l)
  );

  typedef struct {
    string      name;
    logic [2:0] mode;
    logic       serial_in;
    logic [7:0] parallel_in;
    logic [7:0] exp_reg;
  } vec_t;

  typedef struct {
    string      name;
    bit         lsb;
    logic [7:0] reg_content;
    logic       serial_out;
    logic       busy;
    logic       done;
    logic [3:0] bit_count;
  } expect_t;

  expect_t sb_q[$];
  int      n_compared   = 0;
  int      n_mismatched = 0;

  function automatic expect_t mk(string n, bit lsb, logic [7:0] r, logic so,
                                 logic b, logic d, logic [3:0] c);
    expect_t e;
    e.name        = n;
    e.lsb         = lsb;
    e.reg_content = r;
    e.serial_out  = so;
    e.busy        = b;
    e.done        = d;
    e.bit_count   = c;
    return e;
  endfunction

  task automatic compare(string name, logic [31:0] actual, logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_output();
    expect_t e;
    if (sb_q.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb_q.pop_front();
    if (e.lsb) begin
      compare({e.name, ".reg"},  32'(bus_l.reg_content), 32'(e.reg_content));
      compare({e.name, ".sout"}, 32'(bus_l.serial_out),  32'(e.serial_out));
      compare({e.name, ".busy"}, 32'(bus_l.busy),        32'(e.busy));
      compare({e.name, ".done"}, 32'(bus_l.done),        32'(e.done));
      compare({e.name, ".cnt"},  32'(bus_l.bit_count),   32'(e.bit_count));
    end else begin
      compare({e.name, ".reg"},  32'(bus_m.reg_content), 32'(e.reg_content));
      compare({e.name, ".sout"}, 32'(bus_m.serial_out),  32'(e.serial_out));
      compare({e.name, ".busy"}, 32'(bus_m.busy),        32'(e.busy));
      compare({e.name, ".done"}, 32'(bus_m.done),        32'(e.done));
      compare({e.name, ".cnt"},  32'(bus_m.bit_count),   32'(e.bit_count));
    end
  endtask

  // Drive one cycle of inputs, queue what should appear after the edge, then check it.
  task automatic apply_stimulus(bit lsb, logic rst, logic [2:0] mode, logic start,
                                logic si, logic [7:0] pin, expect_t e);
    if (lsb) begin
      reset_l           = rst;
      bus_l.mode        = mode;
      bus_l.start       = start;
      bus_l.serial_in   = si;
      bus_l.parallel_in = pin;
    end else begin
      reset_m           = rst;
      bus_m.mode        = mode;
      bus_m.start       = start;
      bus_m.serial_in   = si;
      bus_m.parallel_in = pin;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_output();
  endtask

  // Guard against a hung simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    vec_t       vecs[12];
    logic [7:0] so_seq;
    logic [7:0] rx;
    logic [7:0] model;
    logic [7:0] emit_l;
    logic       si;

    vecs[0]  = '{"load_a5",  LOAD,   1'b0, 8'hA5, 8'hA5};
    vecs[1]  = '{"shl_1",    SHL,    1'b1, 8'h00, 8'h4B};
    vecs[2]  = '{"shr_0",    SHR,    1'b0, 8'h00, 8'h25};
    vecs[3]  = '{"load_81",  LOAD,   1'b0, 8'h81, 8'h81};
    vecs[4]  = '{"ror",      ROR,    1'b1, 8'h00, 8'hC0};
    vecs[5]  = '{"rol",      ROL,    1'b0, 8'h00, 8'h81};
    vecs[6]  = '{"mode6",    3'd6,   1'b1, 8'h3C, 8'h81};
    vecs[7]  = '{"mode7",    3'd7,   1'b1, 8'h3C, 8'h81};
    vecs[8]  = '{"hold",     HOLD,   1'b1, 8'hFF, 8'h81};
    vecs[9]  = '{"shl_0",    SHL,    1'b0, 8'h00, 8'h02};
    vecs[10] = '{"shr_1",    SHR,    1'b1, 8'h00, 8'h81};
    vecs[11] = '{"ror_lsb0", ROR,    1'b0, 8'h00, 8'hC0};

    reset_m = 1'b1;
    reset_l = 1'b1;
    bus_m.mode = 3'd0; bus_m.start = 1'b0; bus_m.serial_in = 1'b0; bus_m.parallel_in = 8'h00;
    bus_l.mode = 3'd0; bus_l.start = 1'b0; bus_l.serial_in = 1'b0; bus_l.parallel_in = 8'h00;

    $display("[TB] reset and idle");
    apply_stimulus(0, 1'b1, HOLD, 1'b0, 1'b0, 8'h00, mk("reset", 0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0));
    for (int i = 0; i < 3; i++)
      apply_stimulus(0, 1'b0, HOLD, 1'b0, 1'b0, 8'h00, mk("idle", 0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0));

    $display("[TB] manual operations");
    for (int i = 0; i < 12; i++)
      apply_stimulus(0, 1'b0, vecs[i].mode, 1'b0, vecs[i].serial_in, vecs[i].parallel_in,
                     mk(vecs[i].name, 0, vecs[i].exp_reg, vecs[i].exp_reg[7], 1'b0, 1'b0, 4'd0));

    $display("[TB] MSB-first burst 0xA5 out, 0x3C in");
    so_seq = 8'b1010_0101;
    rx     = 8'h3C;
    apply_stimulus(0, 1'b0, ROL, 1'b1, 1'b0, 8'hA5,
                   mk("burst_start", 0, 8'hA5, so_seq[7], 1'b1, 1'b0, 4'd0));
    model = 8'hA5;
    for (int k = 1; k <= 8; k++) begin
      si    = rx[8-k];
      model = {model[6:0], si};
      if (k < 8)
        apply_stimulus(0, 1'b0, LOAD, 1'b1, si, 8'hFF,
                       mk("burst_shift", 0, model, so_seq[7-k], 1'b1, 1'b0, 4'(k)));
      else
        apply_stimulus(0, 1'b0, LOAD, 1'b1, si, 8'hFF,
                       mk("burst_done", 0, 8'h3C, 1'b0, 1'b0, 1'b1, 4'd8));
    end
    apply_stimulus(0, 1'b0, HOLD, 1'b0, 1'b0, 8'h00, mk("burst_after", 0, 8'h3C, 1'b0, 1'b0, 1'b0, 4'd8));

    $display("[TB] reset during burst");
    apply_stimulus(0, 1'b0, HOLD, 1'b1, 1'b0, 8'hFF, mk("abort_start", 0, 8'hFF, 1'b1, 1'b1, 1'b0, 4'd0));
    model = 8'hFF;
    for (int k = 1; k <= 3; k++) begin
      model = {model[6:0], 1'b0};
      apply_stimulus(0, 1'b0, HOLD, 1'b0, 1'b0, 8'h00, mk("abort_shift", 0, model, 1'b1, 1'b1, 1'b0, 4'(k)));
    end
    apply_stimulus(0, 1'b1, HOLD, 1'b0, 1'b0, 8'h00, mk("abort_reset", 0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0));
    apply_stimulus(0, 1'b0, HOLD, 1'b0, 1'b0, 8'h00, mk("abort_nodone", 0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0));
    apply_stimulus(0, 1'b0, HOLD, 1'b1, 1'b1, 8'h5A, mk("rerun_start", 0, 8'h5A, 1'b0, 1'b1, 1'b0, 4'd0));
    model = 8'h5A;
    for (int k = 1; k <= 8; k++) begin
      model = {model[6:0], 1'b1};
      if (k < 8)
        apply_stimulus(0, 1'b0, HOLD, 1'b0, 1'b1, 8'h00, mk("rerun_shift", 0, model, model[7], 1'b1, 1'b0, 4'(k)));
      else
        apply_stimulus(0, 1'b0, HOLD, 1'b0, 1'b1, 8'h00, mk("rerun_done", 0, 8'hFF, 1'b1, 1'b0, 1'b1, 4'd8));
    end

    $display("[TB] LSB-first burst and back-to-back start");
    apply_stimulus(1, 1'b1, HOLD, 1'b0, 1'b0, 8'h00, mk("lsb_reset", 1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0));
    emit_l = 8'b0000_0001;
    apply_stimulus(1, 1'b0, HOLD, 1'b1, 1'b1, 8'h01, mk("lsb_start", 1, 8'h01, emit_l[0], 1'b1, 1'b0, 4'd0));
    model = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      model = {1'b1, model[7:1]};
      if (k < 8)
        apply_stimulus(1, 1'b0, HOLD, 1'b0, 1'b1, 8'h00, mk("lsb_shift", 1, model, emit_l[k], 1'b1, 1'b0, 4'(k)));
      else
        apply_stimulus(1, 1'b0, HOLD, 1'b0, 1'b1, 8'h00, mk("lsb_done", 1, 8'hFF, 1'b1, 1'b0, 1'b1, 4'd8));
    end
    apply_stimulus(1, 1'b0, HOLD, 1'b1, 1'b0, 8'h80, mk("b2b_start", 1, 8'h80, 1'b0, 1'b1, 1'b0, 4'd0));
    model = 8'h80;
    for (int k = 1; k <= 8; k++) begin
      model = {1'b0, model[7:1]};
      if (k < 8)
        apply_stimulus(1, 1'b0, HOLD, 1'b0, 1'b0, 8'h00, mk("b2b_shift", 1, model, model[0], 1'b1, 1'b0, 4'(k)));
      else
        apply_stimulus(1, 1'b0, HOLD, 1'b0, 1'b0, 8'h00, mk("b2b_done", 1, 8'h00, 1'b0, 1'b0, 1'b1, 4'd8));
    end
    apply_stimulus(1, 1'b0, HOLD, 1'b0, 1'b0, 8'h00, mk("b2b_after", 1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd8));

    if (sb_q.size() != 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
